// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared widths for the register-write scoreboard.
// The optional WB write-through bypass is selected with the SB_FWD_EN macro.
package reg_scoreboard_pkg;

    localparam int unsigned SB_REG_ADDR_W = 4;
    localparam int unsigned SB_NUM_REGS   = 16;
    localparam int unsigned SB_CNT_W      = 2;
    localparam int unsigned SB_INFLIGHT_W = SB_CNT_W + SB_REG_ADDR_W;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue/retire/source bundle between the ID stage and the scoreboard.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = SB_NUM_REGS,
    parameter int unsigned CNT_W    = SB_CNT_W
);

    logic                         issue_valid;
    logic                         issue_wb_en;
    logic [SB_REG_ADDR_W-1:0]     issue_dest;
    logic                         retire_valid;
    logic [SB_REG_ADDR_W-1:0]     retire_dest;
    logic [SB_REG_ADDR_W-1:0]     src1;
    logic [SB_REG_ADDR_W-1:0]     src2;
    logic                         two_src;
    logic                         hazard;
    logic [NUM_REGS-1:0]          pending;
    logic [CNT_W+SB_REG_ADDR_W-1:0] inflight;
    logic                         err;

    // Pipeline side: drives issue/retire/sources, observes the stall.
    modport master (
        output issue_valid, issue_wb_en, issue_dest,
        output retire_valid, retire_dest,
        output src1, src2, two_src,
        input  hazard, pending, inflight, err
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wb_en, issue_dest,
        input  retire_valid, retire_dest,
        input  src1, src2, two_src,
        output hazard, pending, inflight, err
    );

endinterface : reg_scoreboard_if

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating up/down in-flight counter for one register, sticky error.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_nonzero,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic             r_err;

    // Count update: simultaneous inc/dec cancels; overflow/underflow holds and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: begin
                    if (r_count == CNT_MAX) r_err   <= 1'b1;
                    else                    r_count <= r_count + CNT_W'(1);
                end
                2'b01: begin
                    if (r_count == '0) r_err   <= 1'b1;
                    else               r_count <= r_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_count   = r_count;
    assign o_nonzero = (r_count != '0);
    assign o_err     = r_err;

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks outstanding register writes issued from ID and stalls
// dependent sources. Define SB_FWD_EN to drop the stall in the WB cycle itself.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = SB_NUM_REGS,
    parameter int unsigned CNT_W    = SB_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_scoreboard_if.slave        sb
);

    localparam int unsigned      INF_W   = CNT_W + SB_REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                           w_inc;
    logic                           w_dec;
    logic                           w_same;
    logic                           w_inc_ok;
    logic                           w_dec_ok;
    logic [NUM_REGS-1:0]            w_inc_vec;
    logic [NUM_REGS-1:0]            w_dec_vec;
    logic [NUM_REGS-1:0]            w_nonzero;
    logic [NUM_REGS-1:0]            w_err_vec;
    logic [NUM_REGS-1:0]            w_pend;
    logic [NUM_REGS-1:0][CNT_W-1:0] w_count;
    logic [INF_W-1:0]               r_inflight;

    assign w_inc  = sb.issue_valid & sb.issue_wb_en;
    assign w_dec  = sb.retire_valid;
    assign w_same = w_inc & w_dec & (sb.issue_dest == sb.retire_dest);

    // Per-register counters with one-hot index decode.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        assign w_inc_vec[g] = w_inc & (sb.issue_dest  == SB_REG_ADDR_W'(g));
        assign w_dec_vec[g] = w_dec & (sb.retire_dest == SB_REG_ADDR_W'(g));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst),
            .i_inc     (w_inc_vec[g]),
            .i_dec     (w_dec_vec[g]),
            .o_count   (w_count[g]),
            .o_nonzero (w_nonzero[g]),
            .o_err     (w_err_vec[g])
        );
    end

    // Only count changes that the counters actually apply feed the total.
    assign w_inc_ok = w_inc & ~w_same & (w_count[sb.issue_dest]  != CNT_MAX);
    assign w_dec_ok = w_dec & ~w_same & (w_count[sb.retire_dest] != '0);

    // Running total of outstanding writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + INF_W'(w_inc_ok) - INF_W'(w_dec_ok);
        end
    end

    // Per-register hazard view; the bypass hides a last write retiring this cycle.
    always_comb begin
        w_pend = w_nonzero;
`ifdef SB_FWD_EN
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (sb.retire_valid && (sb.retire_dest == SB_REG_ADDR_W'(r)) &&
                (w_count[r] == CNT_W'(1))) begin
                w_pend[r] = 1'b0;
            end
        end
`endif
    end

    assign sb.hazard   = w_pend[sb.src1] | (sb.two_src & w_pend[sb.src2]);
    assign sb.pending  = w_nonzero;
    assign sb.inflight = r_inflight;
    assign sb.err      = |w_err_vec;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and random traffic against a per-register count model.
module tb_reg_scoreboard;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    // Reference state: plain integer count per register and a sticky error.
    int m_cnt [16];
    bit m_err;

    reg_scoreboard_if sb_if ();

    reg_scoreboard u_dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pend(input int x);
        bit p;
        p = (m_cnt[x] != 0);
`ifdef SB_FWD_EN
        if (sb_if.retire_valid && (int'(sb_if.retire_dest) == x) && (m_cnt[x] == 1)) p = 1'b0;
`endif
        return p;
    endfunction

    task automatic check_outputs(input string tag);
        logic [15:0] exp_pend;
        int          total;
        bit          hz;
        total = 0;
        for (int r = 0; r < 16; r++) begin
            exp_pend[r] = (m_cnt[r] != 0);
            total += m_cnt[r];
        end
        hz = model_pend(int'(sb_if.src1)) | (sb_if.two_src & model_pend(int'(sb_if.src2)));
        check({tag, ".hazard"},   32'(sb_if.hazard),   32'(hz));
        check({tag, ".pending"},  32'(sb_if.pending),  32'(exp_pend));
        check({tag, ".inflight"}, 32'(sb_if.inflight), 32'(total));
        check({tag, ".err"},      32'(sb_if.err),      32'(m_err));
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_err = 1'b0;
    endfunction

    function automatic void model_edge();
        bit inc;
        bit dec;
        int id;
        int rd;
        inc = sb_if.issue_valid & sb_if.issue_wb_en;
        dec = sb_if.retire_valid;
        id  = int'(sb_if.issue_dest);
        rd  = int'(sb_if.retire_dest);
        if (inc && dec && id == rd) return;
        if (inc) begin
            if (m_cnt[id] == 3) m_err = 1'b1;
            else                m_cnt[id]++;
        end
        if (dec) begin
            if (m_cnt[rd] == 0) m_err = 1'b1;
            else                m_cnt[rd]--;
        end
    endfunction

    // One cycle: drive just after an edge, check mid-cycle, advance model at the edge.
    task automatic step(input string tag,
                        input logic iv, input logic iwb, input logic [3:0] idst,
                        input logic rv, input logic [3:0] rdst,
                        input logic [3:0] s1, input logic [3:0] s2, input logic ts);
        sb_if.issue_valid  = iv;
        sb_if.issue_wb_en  = iwb;
        sb_if.issue_dest   = idst;
        sb_if.retire_valid = rv;
        sb_if.retire_dest  = rdst;
        sb_if.src1         = s1;
        sb_if.src2         = s2;
        sb_if.two_src      = ts;
        #3;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] s1, input logic [3:0] s2, input logic ts);
        step(tag, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, s1, s2, ts);
    endtask

    // Asynchronous reset asserted mid-cycle, released between edges.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check_outputs({tag, ".during"});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs({tag, ".after"});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        sb_if.issue_valid  = 1'b0;
        sb_if.issue_wb_en  = 1'b0;
        sb_if.issue_dest   = '0;
        sb_if.retire_valid = 1'b0;
        sb_if.retire_dest  = '0;
        sb_if.src1         = '0;
        sb_if.src2         = '0;
        sb_if.two_src      = 1'b0;
        rst = 1'b0;
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset");

        // Reset mid-traffic with r3 holding two writes.
        step("r3a", 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0);
        step("r3b", 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0);
        idle("r3c", 4'd3, 4'd0, 1'b0);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wb_en = 1'b1;
        pulse_reset("rst_mid");
        sb_if.issue_valid = 1'b0;

        // Single r3 write: stall after issue, released around retire.
        step("iss3", 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) idle("wait3", 4'd3, 4'd0, 1'b0);
        step("ret3", 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0);
        idle("post3", 4'd3, 4'd0, 1'b0);

        // Depth-2 writes to r2.
        step("r2i1", 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd2, 4'd0, 1'b0);
        step("r2i2", 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd2, 4'd0, 1'b0);
        step("r2r1", 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd2, 4'd0, 1'b0);
        step("r2r2", 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd2, 4'd0, 1'b0);
        idle("r2end", 4'd2, 4'd0, 1'b0);

        // Same-register issue/retire at zero; split-register issue/retire.
        step("same7", 1'b1, 1'b1, 4'd7, 1'b1, 4'd7, 4'd7, 4'd0, 1'b0);
        step("iss4",  1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 4'd1, 4'd4, 1'b1);
        step("i1r4",  1'b1, 1'b1, 4'd1, 1'b1, 4'd4, 4'd1, 4'd4, 1'b1);
        idle("i1r4p", 4'd1, 4'd4, 1'b1);

        // wb_en low means no record.
        step("nowb", 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 4'd6, 4'd0, 1'b0);

        // Second-source gating.
        step("iss5", 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 4'd0, 4'd5, 1'b0);
        idle("src2off", 4'd0, 4'd5, 1'b0);
        idle("src2on",  4'd0, 4'd5, 1'b1);

        // Overflow of r9 then underflow of r0.
        for (int i = 0; i < 4; i++) step("ovf9", 1'b1, 1'b1, 4'd9, 1'b0, 4'd0, 4'd9, 4'd0, 1'b0);
        idle("ovf9p", 4'd9, 4'd0, 1'b0);
        pulse_reset("rst_ovf");
        step("unf0", 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
        idle("unf0p", 4'd0, 4'd0, 1'b0);
        pulse_reset("rst_unf");

        // Random traffic over a few registers to build depth; periodic resets clear err.
        for (int i = 0; i < 1500; i++) begin
            if ((i % 250) == 249) begin
                pulse_reset("rnd_rst");
            end else begin
                step("rnd",
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     4'($urandom_range(0, 5)),
                     1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)),
                     4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_scoreboard

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-write scoreboard for the ARM pipeline. It is the writer-side counterpart of stage-comparison hazard detection: it records every destination register issued from ID with write-back enabled and releases it when WB writes it. ID sources are checked against the recorded pending set, so in-flight writes of any depth are covered, including multi-cycle memory stalls. It sits beside the ID stage; `hazard` drives the pipeline freeze and bubble insertion.

## Interface
Parameters:
- NUM_REGS, 16, architectural registers tracked (index width 4)
- CNT_W, 2, per-register in-flight counter width (max 2^CNT_W−1 outstanding writes per register)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  an instruction leaves ID this cycle (caller gates with !hazard and !freeze)
- issue_wb_en  in  1  the issuing instruction writes a register
- issue_dest  in  4  destination of the issuing instruction
- retire_valid  in  1  WB writes the register file this cycle
- retire_dest  in  4  register written by WB
- src1  in  4  first ID source
- src2  in  4  second ID source
- two_src  in  1  src2 is meaningful
- hazard  out  1  ID must stall
- pending  out  NUM_REGS  bit r set when count[r] != 0
- inflight  out  CNT_W+4  total outstanding writes
- err  out  1  sticky overflow/underflow flag

## Operation
- State: count[r] (CNT_W bits) per register, err, inflight.
- inc = issue_valid & issue_wb_en; dec = retire_valid.
- Per register r on each edge:
  - inc only (issue_dest==r): count+1; if count already max, hold and set err.
  - dec only (retire_dest==r): count−1; if count already 0, hold at 0 and set err.
  - inc and dec on the same r: count unchanged, no err, even when count is 0 or max.
  - inc and dec on different registers: both applied independently.
- inflight = sum of counts, updated in the same edge (net +1, −1 or 0); it never wraps because each count is bounded.
- err is sticky until reset.
- hazard = pend(src1) | (two_src & pend(src2)), combinational from current counts. pend(x) = count[x]!=0, subject to the configuration macro.
- No special handling of r15; the PC is tracked like any other register.

## Timing
- Reset (async assert, any cycle, including mid-stall): all counts 0, err 0, inflight 0. Outputs follow immediately: pending 0, hazard 0. Release is sampled at the next rising edge.
- Issue at edge N: pending/hazard reflect it from cycle N+1 (one-cycle latency). No combinational path from issue_* to hazard.
- Retire at edge N: pending bit clears from cycle N+1 when the count reaches 0. Without the macro, hazard therefore drops one cycle after WB.
- retire_* to hazard is combinational only when SB_FWD_EN is defined.

## Configuration
- SB_FWD_EN defined: WB write-through bypass. pend(x) = count[x]!=0 & !(retire_valid & retire_dest==x & count[x]==1). A source whose only outstanding write retires this cycle is not a hazard, so the stall ends in the WB cycle. The register file must write in the first half-cycle or forward.
- SB_FWD_EN undefined: pend(x) = count[x]!=0. Stall ends the cycle after WB. No retire-to-hazard combinational path.

## Structure
- Shared defines file: REG_ADDR_W (4), NUM_REGS (16), SB_CNT_W (2), and the SB_FWD_EN switch.
- One sub-module, `sb_counter`: a CNT_W-bit saturating up/down counter with inc, dec, async active-low reset, nonzero and err outputs. It is instantiated NUM_REGS times via generate.
- The top level handles index decode, the hazard mux, inflight accumulation and err OR-reduction.

## Test plan
- Reset mid-traffic with count[3]=2: assert rst low between edges -> pending, hazard, inflight and err are 0 immediately; still 0 after release.
- Issue r3 at edge 1, src1=3 -> hazard=0 in cycle 1, 1 in cycle 2. Retire r3 at edge 5 -> hazard=1 through cycle 5 and 0 in cycle 6 (macro off). With macro on, hazard=0 in the retire cycle 5.
- Issue r2 twice, retire r2 once -> pending[2] stays 1, inflight=1. Second retire -> pending[2]=0, inflight=0.
- Simultaneous issue r7 and retire r7 with count[7]=0 -> count stays 0, err=0. Simultaneous issue r1 and retire r4 -> pending[1]=1, pending[4] cleared.
- two_src=0, src2=5 pending, src1 idle -> hazard=0. two_src=1 -> hazard=1.
- Four issues to r9 with CNT_W=2 -> count holds 3, err=1 sticky. Retire of r0 at count 0 -> err=1, count 0.
